asip_pipe_ctrl: RTL

- Parametrised hazard and pipeline-control block for the vector ASIP pipeline; replaces the fixed branch-only stall logic.
- Tracks in-flight PC-writing instructions across a configurable number of stages.
- Detects load-use hazards on the vector register file and produces per-operand forwarding selects for the execute stage.
- Sits beside the datapath; drives its stall, flush and forward-mux controls.

---
 rtl/asip_pipe_pkg.sv | 15 +
 rtl/asip_fwd_sel.sv | 32 +++
 rtl/asip_pipe_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/asip_pipe_pkg.sv
// Shared types and defaults for the vector ASIP pipeline control.
// Optional perf counters in asip_pipe_ctrl are enabled by ASIP_PIPE_PERF_EN.
package asip_pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam int STAGES_DEF     = 5;
  localparam int REG_ADDR_W_DEF = 4;
  localparam int CNT_W_DEF      = 16;

endpackage

// File: rtl/asip_fwd_sel.sv
// Per-operand forwarding select for the execute stage.
// M-stage ALU results win over W; loads in M are not forwarded.
module asip_fwd_sel
  import asip_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] ra,
  input  logic [REG_ADDR_W-1:0] wa3_m,
  input  logic [REG_ADDR_W-1:0] wa3_w,
  input  logic                  reg_write_m,
  input  logic                  mem_to_reg_m,
  input  logic                  reg_write_w,
  output fwd_sel_t              sel
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_write_m & ~mem_to_reg_m
               & (wa3_m == ra);
  assign hit_w = reg_write_w & (wa3_w == ra);

  always_comb begin
    sel = FWD_RF;
    if (hit_m)
      sel = FWD_M;
    else if (hit_w)
      sel = FWD_W;
  end

endmodule

// File: rtl/asip_pipe_ctrl.sv
// Stall/flush/forward control for the vector ASIP pipeline.
// Define ASIP_PIPE_PERF_EN to enable saturating stall/flush counters.
module asip_pipe_ctrl
  import asip_pipe_pkg::*;
#(
  parameter int STAGES     = STAGES_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_d,
  input  logic                  pcs_d,
  input  logic                  use1_d,
  input  logic                  use2_d,
  input  logic [REG_ADDR_W-1:0] ra1_d,
  input  logic [REG_ADDR_W-1:0] ra2_d,
  input  logic [REG_ADDR_W-1:0] ra1_e,
  input  logic [REG_ADDR_W-1:0] ra2_e,
  input  logic [REG_ADDR_W-1:0] wa3_e,
  input  logic [REG_ADDR_W-1:0] wa3_m,
  input  logic [REG_ADDR_W-1:0] wa3_w,
  input  logic                  reg_write_e,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  input  logic                  mem_to_reg_e,
  input  logic                  mem_to_reg_m,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int BQ_W = STAGES - 2;

  logic [BQ_W-1:0] brq;
  logic            br_in;
  logic            br_stall;
  logic            lu;
  logic            hit1;
  logic            hit2;
  fwd_sel_t        sel_a;
  fwd_sel_t        sel_b;

  assign hit1 = use1_d & (wa3_e == ra1_d);
  assign hit2 = use2_d & (wa3_e == ra2_d);

  assign lu = mem_to_reg_e & reg_write_e
            & valid_d & (hit1 | hit2);

  // A held branch (stall_d) re-presents next cycle, so it enters then.
  assign br_in    = pcs_d & valid_d & ~stall_d;
  assign br_stall = (pcs_d & valid_d) | (|brq);

  assign stall_f = br_stall | lu;
  assign stall_d = lu;
  assign flush_e = lu;
  assign flush_d = (|brq) & ~lu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      brq <= '0;
    else
      brq <= {brq[BQ_W-2:0], br_in};
  end

  asip_fwd_sel #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_a (
    .ra           (ra1_e),
    .wa3_m        (wa3_m),
    .wa3_w        (wa3_w),
    .reg_write_m  (reg_write_m),
    .mem_to_reg_m (mem_to_reg_m),
    .reg_write_w  (reg_write_w),
    .sel          (sel_a)
  );

  asip_fwd_sel #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_b (
    .ra           (ra2_e),
    .wa3_m        (wa3_m),
    .wa3_w        (wa3_w),
    .reg_write_m  (reg_write_m),
    .mem_to_reg_m (mem_to_reg_m),
    .reg_write_w  (reg_write_w),
    .sel          (sel_b)
  );

  assign fwd_a_e = sel_a;
  assign fwd_b_e = sel_b;

`ifdef ASIP_PIPE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
      if ((flush_d | flush_e) && !(&flush_cnt))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
